// File: rtl/mac_term_scheduler.sv
// Complex dot-product scheduler driving one shared combinational FP MAC.
// Ports: clk, reset (sync, active-high); start/num_terms/busy control;
//   op_valid/op_ready/op_idx + op_g_*/op_s_* operand fetch;
//   mac_a/mac_b/mac_c/mac_rnd out, mac_z/mac_status in (z = a*b + c);
//   res_valid/res_ready + res_re/res_im/res_status result; done pulse.
module mac_term_scheduler #(
    parameter int DW    = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   num_terms,
    output logic             busy,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [IDX_W-1:0] op_idx,
    input  logic [DW-1:0]    op_g_re,
    input  logic [DW-1:0]    op_g_im,
    input  logic [DW-1:0]    op_s_re,
    input  logic [DW-1:0]    op_s_im,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic [DW-1:0]    mac_c,
    output logic [2:0]       mac_rnd,
    input  logic [DW-1:0]    mac_z,
    input  logic [7:0]       mac_status,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_re,
    output logic [DW-1:0]    res_im,
    output logic [7:0]       res_status,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, MAC0, MAC1, MAC2, MAC3, OUT
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W:0]   n_q;
    logic [IDX_W-1:0] k;
    logic [DW-1:0]    acc_re, acc_im;
    logic [DW-1:0]    g_re, g_im, s_re, s_im;
    logic [7:0]       stat_acc;
    logic             done_q;
    logic             last;

    assign last = ({1'b0, k} == n_q - (IDX_W+1)'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)
                state_nxt = (num_terms == '0) ? OUT : FETCH;
            FETCH: if (op_valid) state_nxt = MAC0;
            MAC0: state_nxt = MAC1;
            MAC1: state_nxt = MAC2;
            MAC2: state_nxt = MAC3;
            MAC3: state_nxt = last ? OUT : FETCH;
            OUT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q      <= '0;
            k        <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            g_re     <= '0;
            g_im     <= '0;
            s_re     <= '0;
            s_im     <= '0;
            stat_acc <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == OUT) && res_ready;
            unique case (state)
                IDLE: if (start) begin
                    n_q      <= num_terms;
                    k        <= '0;
                    acc_re   <= '0;
                    acc_im   <= '0;
                    stat_acc <= '0;
                end
                FETCH: if (op_valid) begin
                    g_re <= op_g_re;
                    g_im <= op_g_im;
                    s_re <= op_s_re;
                    s_im <= op_s_im;
                end
                MAC0, MAC1: begin
                    acc_re   <= mac_z;
                    stat_acc <= stat_acc | mac_status;
                end
                MAC2: begin
                    acc_im   <= mac_z;
                    stat_acc <= stat_acc | mac_status;
                end
                MAC3: begin
                    acc_im   <= mac_z;
                    stat_acc <= stat_acc | mac_status;
                    if (!last) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // MAC1 subtracts g_im*s_im by negating the multiplicand's sign bit.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        unique case (state)
            MAC0: begin mac_a = g_re; mac_b = s_re; mac_c = acc_re; end
            MAC1: begin
                mac_a = {~g_im[DW-1], g_im[DW-2:0]};
                mac_b = s_im;
                mac_c = acc_re;
            end
            MAC2: begin mac_a = g_re; mac_b = s_im; mac_c = acc_im; end
            MAC3: begin mac_a = g_im; mac_b = s_re; mac_c = acc_im; end
            default: ;
        endcase
    end

    assign mac_rnd    = 3'b000;
    assign busy       = (state != IDLE);
    assign op_ready   = (state == FETCH);
    assign op_idx     = k;
    assign res_valid  = (state == OUT);
    assign res_re     = res_valid ? acc_re   : '0;
    assign res_im     = res_valid ? acc_im   : '0;
    assign res_status = res_valid ? stat_acc : '0;
    assign done       = done_q;

endmodule

// File: doc/mac_term_scheduler.md
MAC_TERM_SCHEDULER -- requirements
Module: mac_term_scheduler

Interface
REQ-001 The block SHALL have parameter DW, default 64, meaning IEEE-754 double word width of every operand and result.
REQ-002 The block SHALL have parameter IDX_W, default 6, meaning term index width, so at most 2^IDX_W = 64 terms per dot product.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin one complex dot product; sampled only in IDLE.
REQ-006 The block SHALL have port num_terms, input, IDX_W+1 bits: term count N (0..64); sampled on the accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-008 The block SHALL have ports op_valid (input, 1 bit) and op_ready (output, 1 bit): handshake for one operand set.
REQ-009 The block SHALL have port op_idx, output, IDX_W bits: index k of the operand set being requested.
REQ-010 The block SHALL have ports op_g_re, op_g_im, op_s_re, op_s_im, all input, DW bits each: gate element G[k] and state element S[k].
REQ-011 The block SHALL have ports mac_a, mac_b, mac_c (output, DW bits each), mac_rnd (output, 3 bits), mac_z (input, DW bits) and mac_status (input, 8 bits): connection to one shared combinational DW_fp_mac where z = a*b + c.
REQ-012 The block SHALL have ports res_valid (output, 1 bit), res_ready (input, 1 bit), res_re and res_im (output, DW bits each), and res_status (output, 8 bits): the result handshake and payload.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after the result is accepted.

Function
REQ-014 The block SHALL compute res = sum over k=0..N-1 of G[k]*S[k] in complex arithmetic, using only the shared MAC.
REQ-015 The FSM SHALL have states IDLE, FETCH, MAC0, MAC1, MAC2, MAC3 and OUT.
REQ-016 In IDLE, start=1 SHALL latch num_terms, clear acc_re, acc_im and stat_acc to zero (+0.0 is 0x0), and set k=0; next state is FETCH if N>0, else OUT.
REQ-017 In FETCH, op_ready SHALL be 1 and op_idx SHALL equal k; when op_valid=1, the four operand words SHALL be latched and the next state is MAC0; otherwise the FSM stays in FETCH.
REQ-018 MAC0 SHALL drive a=g_re, b=s_re, c=acc_re and register acc_re<=mac_z.
REQ-019 MAC1 SHALL drive a=g_im with bit DW-1 inverted, b=s_im, c=acc_re and register acc_re<=mac_z.
REQ-020 MAC2 SHALL drive a=g_re, b=s_im, c=acc_im and register acc_im<=mac_z.
REQ-021 MAC3 SHALL drive a=g_im, b=s_re, c=acc_im and register acc_im<=mac_z.
REQ-022 After MAC3, if k==N-1 the next state SHALL be OUT; otherwise k SHALL increment and the next state is FETCH.
REQ-023 In every MAC state, stat_acc SHALL be updated to stat_acc OR mac_status, so the flags are sticky.
REQ-024 Outside the MAC states, mac_a, mac_b and mac_c SHALL be 0; mac_rnd SHALL always be 3'b000 (round to nearest even).
REQ-025 In OUT, res_valid SHALL be 1, with res_re=acc_re, res_im=acc_im and res_status=stat_acc held stable until res_ready=1; on res_ready=1 the next state is IDLE and done pulses in the following cycle.
REQ-026 start SHALL be ignored while busy=1; op_valid SHALL be ignored outside FETCH.
REQ-027 Timing: with op_valid held high, start accepted at cycle T SHALL give res_valid=1 at cycle T+1+5N; with N=0 it SHALL give res_valid=1 at T+1.
REQ-028 Each op_valid stall cycle in FETCH SHALL add exactly one cycle of latency.

Reset
REQ-029 On reset=1 at a clock edge, the next state SHALL be IDLE, with busy, op_ready, res_valid and done at 0, and op_idx, res_re, res_im, res_status, acc_re, acc_im, stat_acc and k at 0.
REQ-030 Reset asserted in any state, including mid-MAC or in OUT, SHALL abandon the operation with no done pulse; start is accepted from the first cycle after reset deasserts.

Verification
REQ-031 N=1, G0=(0x3FF0000000000000, 0), S0=(0x4000000000000000, 0x4008000000000000), op_valid high -> res_re=0x4000000000000000 (2.0), res_im=0x4008000000000000 (3.0), res_valid at T+6, res_status=0.
REQ-032 N=2, G=(0.5,0),(0.5,0), S=(1,0),(1,0) -> res=(0x3FF0000000000000, 0), res_valid at T+11, op_idx sequence 0 then 1.
REQ-033 N=1, G0=(0,1.0), S0=(0,1.0) -> res_re=0xBFF0000000000000 (-1.0), res_im=0; this checks the sign flip in MAC1.
REQ-034 N=0 -> res_valid at T+1 with res_re=res_im=0, no op_ready pulse, and done one cycle after res_ready.
REQ-035 Backpressure: res_ready low for 3 cycles, start pulsed during OUT -> result words held constant, start ignored, a single done pulse.
REQ-036 Reset asserted during MAC2 of term 1 with N=4 -> next cycle busy=0, res_valid=0, op_ready=0; a fresh start with N=1 then produces a correct result.
